// File: rtl/cache_pkg.sv
// Shared cache geometry, address field positions, fill FSM states and the
// metadata byte layout used by the miss-fill controller.
package cache_pkg;

  localparam int unsigned ADDR_W          = 16;
  localparam int unsigned WORD_W          = 16;
  localparam int unsigned NUM_BLOCKS      = 128;
  localparam int unsigned WORDS_PER_BLOCK = 8;
  localparam int unsigned TAG_W           = 5;
  localparam int unsigned INDEX_W         = 7;
  localparam int unsigned WORD_SEL_W      = 3;
  localparam int unsigned META_W          = 8;
  localparam int unsigned CNT_W           = 4;

  // Byte-address field positions: tag[15:11], index[10:4], word[3:1].
  localparam int unsigned TAG_LSB   = 11;
  localparam int unsigned INDEX_LSB = 4;
  localparam int unsigned WORD_LSB  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  typedef struct packed {
    logic             valid;
    logic [1:0]       rsvd;
    logic [TAG_W-1:0] tag;
  } meta_t;

  function automatic meta_t make_meta(input logic [TAG_W-1:0] tag);
    meta_t m;
    m.valid = 1'b1;
    m.rsvd  = 2'b00;
    m.tag   = tag;
    return m;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Binary to one-hot decoder with enable; all-zero output when disabled.
module onehot_dec #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]        sel,
  input  logic                en,
  output logic [(2**N)-1:0]   onehot_c
);

  always_comb begin
    onehot_c = '0;
    if (en) onehot_c[sel] = 1'b1;
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss-fill controller: requests the eight words of a missing block from
// pipelined memory, writes each returned word and finally the tag/valid byte.
module cache_fill_ctrl #(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned WORD_W          = 16,
  parameter int unsigned NUM_BLOCKS      = 128,
  parameter int unsigned WORDS_PER_BLOCK = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        miss_detected,
  input  logic [ADDR_W-1:0]           miss_address,
  input  logic                        memory_data_valid,
  input  logic [WORD_W-1:0]           memory_data,
  output logic                        fsm_busy,
  output logic                        mem_read,
  output logic [ADDR_W-1:0]           memory_address,
  output logic                        write_data_array,
  output logic                        write_tag_array,
  output logic [NUM_BLOCKS-1:0]       block_enable,
  output logic [WORDS_PER_BLOCK-1:0]  word_enable,
  output logic [WORD_W-1:0]           data_out,
  output logic [7:0]                  meta_out
);

  import cache_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_BLOCKS);
  localparam int unsigned SEL_W = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned BLK_W = ADDR_W - INDEX_LSB;

  fill_state_e       state, state_nxt;
  logic [BLK_W-1:0]  blk_addr, blk_addr_nxt;
  logic [CNT_W-1:0]  req_cnt, req_cnt_nxt;
  logic [CNT_W-1:0]  rsp_cnt, rsp_cnt_nxt;
  logic              blk_dec_en;
  logic              word_dec_en;
  logic [TAG_W-1:0]  blk_tag;
  logic              unused_offset;

  // Byte offset within the block is irrelevant to a whole-block fill.
  assign unused_offset = ^miss_address[INDEX_LSB-1:0];
  assign blk_tag       = blk_addr[BLK_W-1 -: TAG_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      blk_addr <= '0;
      req_cnt  <= '0;
      rsp_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      blk_addr <= blk_addr_nxt;
      req_cnt  <= req_cnt_nxt;
      rsp_cnt  <= rsp_cnt_nxt;
    end
  end

  // Request and response counters advance independently; the eighth
  // response closes the fill regardless of how far requests have run ahead.
  always_comb begin
    state_nxt        = state;
    blk_addr_nxt     = blk_addr;
    req_cnt_nxt      = req_cnt;
    rsp_cnt_nxt      = rsp_cnt;
    fsm_busy         = 1'b0;
    mem_read         = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    data_out         = '0;
    meta_out         = '0;
    blk_dec_en       = 1'b0;
    word_dec_en      = 1'b0;

    case (state)
      IDLE: begin
        if (miss_detected) begin
          state_nxt    = FILL;
          blk_addr_nxt = miss_address[ADDR_W-1:INDEX_LSB];
          req_cnt_nxt  = '0;
          rsp_cnt_nxt  = '0;
        end
      end

      FILL: begin
        fsm_busy       = 1'b1;
        blk_dec_en     = 1'b1;
        memory_address = ADDR_W'({blk_addr, req_cnt[SEL_W-1:0], 1'b0});
        if (req_cnt < CNT_W'(WORDS_PER_BLOCK)) begin
          mem_read    = 1'b1;
          req_cnt_nxt = req_cnt + CNT_W'(1);
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          word_dec_en      = 1'b1;
          data_out         = memory_data;
          rsp_cnt_nxt      = rsp_cnt + CNT_W'(1);
          if (rsp_cnt == CNT_W'(WORDS_PER_BLOCK - 1)) begin
            write_tag_array = 1'b1;
            meta_out        = make_meta(blk_tag);
            state_nxt       = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  onehot_dec #(.N(IDX_W)) u_block_dec (
    .sel      (blk_addr[IDX_W-1:0]),
    .en       (blk_dec_en),
    .onehot_c (block_enable)
  );

  onehot_dec #(.N(SEL_W)) u_word_dec (
    .sel      (rsp_cnt[SEL_W-1:0]),
    .en       (word_dec_en),
    .onehot_c (word_enable)
  );

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: a pipelined memory emulator plus a block-fill
// model checked against the DUT every cycle, and literal timing expectations.
module tb_cache_fill_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         miss_detected = 1'b0;
  logic [15:0]  miss_address = 16'h0;
  logic         memory_data_valid = 1'b0;
  logic [15:0]  memory_data = 16'h0;
  logic         fsm_busy, mem_read, write_data_array, write_tag_array;
  logic [15:0]  memory_address, data_out;
  logic [127:0] block_enable;
  logic [7:0]   word_enable, meta_out;

  always #5 clk = ~clk;

  cache_fill_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_read          (mem_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .block_enable      (block_enable),
    .word_enable       (word_enable),
    .data_out          (data_out),
    .meta_out          (meta_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // Memory emulator: answers requests in order after lat cycles, optional gaps.
  typedef struct { logic [15:0] a; int t; } req_t;
  req_t q[$];
  int   lat = 4;
  bit   gaps = 1'b0;
  bit   force_valid = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (force_valid) begin
      memory_data_valid = 1'b1;
      memory_data       = 16'hBEEF;
    end else if (q.size() > 0 && q[0].t + lat <= cyc && (!gaps || (cyc % 3) != 1)) begin
      memory_data_valid = 1'b1;
      memory_data       = mem_word(q[0].a);
      q.delete(0);
    end else begin
      memory_data_valid = 1'b0;
      memory_data       = 16'h0;
    end
  end

  // Block-fill model: busy flag, base address, words requested / received.
  bit          m_busy = 1'b0;
  logic [15:0] m_base = 16'h0;
  int          m_req = 0;
  int          m_rsp = 0;

  // Event log for the current fill, in cycles relative to miss acceptance.
  int          rel = -1;
  int          first_req_rel = -1, last_req_rel = -1, first_wr_rel = -1;
  int          tag_rel = -1, drop_rel = -1, n_wr = 0, tag_cnt = 0;
  logic [15:0] first_req_addr = 16'h0, last_req_addr = 16'h0;
  logic [7:0]  meta_seen = 8'h0;
  logic [127:0] blk_seen = '0;

  always @(negedge clk) begin
    bit e_read, e_wr, e_tag;
    if (!rst) begin
      chk("rst_busy", 128'(fsm_busy), 128'(0));
      chk("rst_read", 128'(mem_read), 128'(0));
      chk("rst_addr", 128'(memory_address), 128'(0));
      chk("rst_wda", 128'(write_data_array), 128'(0));
      chk("rst_wta", 128'(write_tag_array), 128'(0));
      chk("rst_blk", block_enable, 128'(0));
      chk("rst_we", 128'(word_enable), 128'(0));
      chk("rst_data", 128'(data_out), 128'(0));
      chk("rst_meta", 128'(meta_out), 128'(0));
      m_busy = 1'b0;
      m_req  = 0;
      m_rsp  = 0;
    end else begin
      if (rel >= 0) rel++;
      e_read = m_busy && m_req < 8;
      e_wr   = m_busy && memory_data_valid;
      e_tag  = e_wr && m_rsp == 7;
      chk("busy", 128'(fsm_busy), 128'(m_busy));
      chk("mem_read", 128'(mem_read), 128'(e_read));
      chk("write_data", 128'(write_data_array), 128'(e_wr));
      chk("write_tag", 128'(write_tag_array), 128'(e_tag));
      chk("block_en", block_enable, m_busy ? (128'(1) << m_base[10:4]) : 128'(0));
      if (e_read) chk("req_addr", 128'(memory_address), 128'(m_base + 16'(2 * m_req)));
      chk("word_en", 128'(word_enable), e_wr ? 128'(8'(1) << m_rsp) : 128'(0));
      chk("data_out", 128'(data_out), e_wr ? 128'(mem_word(m_base + 16'(2 * m_rsp))) : 128'(0));
      chk("meta_out", 128'(meta_out), e_tag ? 128'({1'b1, 2'b00, m_base[15:11]}) : 128'(0));

      if (mem_read) begin
        q.push_back('{a: memory_address, t: cyc});
        if (first_req_rel < 0) begin
          first_req_rel  = rel;
          first_req_addr = memory_address;
        end
        last_req_rel  = rel;
        last_req_addr = memory_address;
        if (rel == 1) blk_seen = block_enable;
      end
      if (write_data_array) begin
        n_wr++;
        if (first_wr_rel < 0) first_wr_rel = rel;
      end
      if (write_tag_array) begin
        tag_cnt++;
        tag_rel   = rel;
        meta_seen = meta_out;
      end
      if (rel > 0 && !fsm_busy && drop_rel < 0) drop_rel = rel;

      if (!m_busy) begin
        if (miss_detected) begin
          m_busy = 1'b1;
          m_base = {miss_address[15:4], 4'h0};
          m_req  = 0;
          m_rsp  = 0;
          rel = 0; first_req_rel = -1; last_req_rel = -1; first_wr_rel = -1;
          tag_rel = -1; drop_rel = -1; n_wr = 0; blk_seen = '0;
        end
      end else begin
        if (m_req < 8) m_req++;
        if (memory_data_valid) begin
          if (m_rsp == 7) m_busy = 1'b0;
          m_rsp++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_miss(input logic [15:0] a);
    miss_address  = a;
    miss_detected = 1'b1;
    tick();
    miss_detected = 1'b0;
  endtask

  task automatic wait_tag(input int prev, input string name);
    int n = 0;
    while (tag_cnt == prev && n < 200) begin
      tick();
      n++;
    end
    chk(name, 128'(tag_cnt != prev), 128'(1));
  endtask

  initial begin
    int prev;
    int n;

    // Reset held with valid asserted, then released while idle.
    force_valid = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    force_valid = 1'b0;
    tick();

    // Single miss at 0xA5B6, latency 4.
    lat = 4; gaps = 1'b0;
    prev = tag_cnt;
    pulse_miss(16'hA5B6);
    wait_tag(prev, "a5b6_timeout");
    tick();
    chk("a5b6_first_req_rel", 128'(first_req_rel), 128'(1));
    chk("a5b6_first_req_addr", 128'(first_req_addr), 128'(16'hA5B0));
    chk("a5b6_last_req_rel", 128'(last_req_rel), 128'(8));
    chk("a5b6_last_req_addr", 128'(last_req_addr), 128'(16'hA5BE));
    chk("a5b6_first_wr_rel", 128'(first_wr_rel), 128'(5));
    chk("a5b6_tag_rel", 128'(tag_rel), 128'(12));
    chk("a5b6_meta", 128'(meta_seen), 128'(8'h94));
    chk("a5b6_drop_rel", 128'(drop_rel), 128'(13));
    chk("a5b6_block_bit", blk_seen, 128'(1) << 91);
    chk("a5b6_n_wr", 128'(n_wr), 128'(8));

    // Latency 1 with irregular response gaps.
    lat = 1; gaps = 1'b1;
    prev = tag_cnt;
    pulse_miss(16'h3C48);
    wait_tag(prev, "gap_timeout");
    tick();
    chk("gap_n_wr", 128'(n_wr), 128'(8));
    chk("gap_tag_count", 128'(tag_cnt), 128'(prev + 1));
    chk("gap_drop_after_tag", 128'(drop_rel), 128'(tag_rel + 1));
    chk("gap_first_req_addr", 128'(first_req_addr), 128'(16'h3C40));

    // Miss at 0x1230 raised mid-fill of 0xFFF0 must be ignored.
    lat = 3; gaps = 1'b0;
    prev = tag_cnt;
    pulse_miss(16'hFFF0);
    repeat (3) tick();
    miss_address  = 16'h1230;
    miss_detected = 1'b1;
    repeat (2) tick();
    miss_detected = 1'b0;
    wait_tag(prev, "ign_timeout");
    tick();
    chk("ign_block_bit", blk_seen, 128'(1) << 127);
    chk("ign_first_req_addr", 128'(first_req_addr), 128'(16'hFFF0));
    chk("ign_last_req_addr", 128'(last_req_addr), 128'(16'hFFFE));
    chk("ign_n_wr", 128'(n_wr), 128'(8));
    chk("ign_no_refill", 128'(fsm_busy), 128'(0));

    // Reset pulse after the third word, then a fresh fill from word 0.
    lat = 2;
    prev = tag_cnt;
    pulse_miss(16'h0420);
    n = 0;
    while (n_wr < 3 && n < 100) begin
      tick();
      n++;
    end
    chk("rst3_reached", 128'(n_wr), 128'(3));
    @(posedge clk);
    #2;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    #1;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst3_no_tag", 128'(tag_cnt), 128'(prev));
    pulse_miss(16'h0420);
    wait_tag(prev, "rst3_refill_timeout");
    tick();
    chk("rst3_refill_addr", 128'(first_req_addr), 128'(16'h0420));
    chk("rst3_refill_first_wr", 128'(first_wr_rel), 128'(3));
    chk("rst3_refill_n_wr", 128'(n_wr), 128'(8));

    // Back-to-back: miss held high, second block accepted on first idle cycle.
    lat = 4;
    prev = tag_cnt;
    miss_address  = 16'h7770;
    miss_detected = 1'b1;
    tick();
    miss_address  = 16'h8880;
    wait_tag(prev, "b2b_first_timeout");
    @(negedge clk);
    #1;
    chk("b2b_idle_gap", 128'(fsm_busy), 128'(0));
    @(negedge clk);
    #1;
    chk("b2b_second_busy", 128'(fsm_busy), 128'(1));
    chk("b2b_second_read", 128'(mem_read), 128'(1));
    chk("b2b_second_addr", 128'(memory_address), 128'(16'h8880));
    miss_detected = 1'b0;
    wait_tag(prev + 1, "b2b_second_timeout");
    tick();
    chk("b2b_second_n_wr", 128'(n_wr), 128'(8));
    chk("b2b_second_meta", 128'(meta_seen), 128'(8'h91));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss-handling writer for the direct-mapped cache (128 blocks × 8 sixteen-bit words, 8-bit metadata per block). On a miss it issues eight word reads to main memory, writes each returned word into the data array, and writes the new tag/valid byte into the metadata array with the last word. It sits between the cache hit/miss compare logic and the pipelined main memory. It drives the write, word-enable, block-enable and data inputs of the cache arrays.

## Interface
Parameters:
- ADDR_W, 16, byte address width
- WORD_W, 16, memory/data-array word width
- NUM_BLOCKS, 128, cache blocks (index width 7)
- WORDS_PER_BLOCK, 8, words per block (offset word field 3 bits)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- miss_detected  in  1  pulse/level from compare logic; sampled only in IDLE
- miss_address  in  16  byte address of missing access
- memory_data_valid  in  1  a requested word is on memory_data this cycle
- memory_data  in  16  returned word
- fsm_busy  out  1  fill in progress; stalls pipeline
- mem_read  out  1  read request to memory this cycle
- memory_address  out  16  word-aligned request address
- write_data_array  out  1  data-array write strobe
- write_tag_array  out  1  metadata-array write strobe
- block_enable  out  128  one-hot, latched miss index
- word_enable  out  8  one-hot, word being written
- data_out  out  16  word to data array (= memory_data)
- meta_out  out  8  {1'b1 valid, 2'b00, tag[4:0]}

## Operation
- Address split: tag = addr[15:11], index = addr[10:4], word = addr[3:1], addr[0] ignored.
- States: IDLE, FILL.
- IDLE: miss_detected=1 → latch miss_address[15:4], clear req_cnt and rsp_cnt (4 bits each), go FILL.
- FILL: mem_read = (req_cnt < 8); memory_address = {latched[15:4], req_cnt[2:0], 1'b0}; req_cnt increments per request.
- FILL with memory_data_valid: write_data_array=1, word_enable = one-hot(rsp_cnt[2:0]), data_out = memory_data; rsp_cnt increments.
- Response with rsp_cnt==7: additionally write_tag_array=1, meta_out from latched tag; next state IDLE.
- block_enable = one-hot(latched index) while FILL, else all zero.
- Words fill in order 0..7; memory returns in request order.
- miss_detected while FILL: ignored (no re-latch, no restart).
- memory_data_valid in IDLE: ignored, no strobes.
- Counters are independent; a response may arrive in the same cycle as a request.

## Timing
- Reset values: state IDLE, counters 0, fsm_busy 0, mem_read 0, write_data_array 0, write_tag_array 0, memory_address 0, block_enable 0, word_enable 0, data_out 0, meta_out 0.
- All request/strobe outputs are combinational from registered state/counters plus memory_data_valid; no registered output delay.
- Miss accepted at edge of cycle 0 → fsm_busy=1 and first mem_read in cycle 1; requests in cycles 1–8.
- With 4-cycle memory latency: words written in cycles 5–12, tag written in cycle 12, fsm_busy=0 in cycle 13 (13-cycle penalty). The controller depends only on memory_data_valid, not on the latency value.
- rst asserted mid-fill: immediate return to IDLE, all outputs 0, tag not written. The cache arrays share rst and clear as well.
- New miss accepted no earlier than the cycle fsm_busy returns to 0.

## Structure
- Shared package cache_pkg: NUM_BLOCKS, WORDS_PER_BLOCK, TAG_W=5, INDEX_W=7, field bit positions, state enum {IDLE, FILL}, meta-byte layout.
- One sub-module: onehot_dec (parameterised N→2^N decoder), instantiated twice (7→128 block, 3→8 word).

## Test plan
- Reset: hold rst=0 and drive memory_data_valid=1 → all outputs 0. Release: still IDLE, fsm_busy=0.
- Single miss at 0xA5B6, memory latency 4 → mem_read addresses 0xA5B0..0xA5BE in cycles 1–8. Words written in cycles 5–12 with word_enable 0x01..0x80 and block_enable bit 0x5B. Cycle 12 write_tag_array=1 and meta_out=0x94. Cycle 13 fsm_busy=0.
- Latency 1 (responses overlap requests) and irregular valid gaps → exactly 8 data writes in order, one tag write, busy drops the cycle after the 8th word.
- miss_detected pulsed at 0x1230 during a fill of 0xFFF0 → no effect; all requests use 0xFFF0 block; block_enable bit 127 only.
- rst pulsed low after the 3rd word → outputs 0 that cycle, no tag write. A following miss restarts at word 0.
- Back-to-back misses, second held high → second miss accepted on the first IDLE cycle, first request one cycle later.
